// File: rtl/dbgu32_host_if.sv
// Request, UART byte and response signals between a dbgu32_host and its environment.
// master is the host's own view; slave is the controller/UART side.
interface dbgu32_host_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_byte;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    modport master (
        input  req_valid, req_we, req_adr, req_wdata, tx_ready, rx_valid, rx_byte,
        output req_ready, tx_valid, tx_byte, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        output req_valid, req_we, req_adr, req_wdata, tx_ready, rx_valid, rx_byte,
        input  req_ready, tx_valid, tx_byte, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/dbgu32_host.sv
// dbgu32 host initiator: serialises a word read/write into the dbgu32 command byte
// stream and reassembles the 4-byte read response, aborting a stalled read on timeout.
module dbgu32_host #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1000000,
    parameter logic [7:0]  CMD_SET_ADR    = 8'h01,
    parameter logic [7:0]  CMD_WRITE      = 8'h04,
    parameter logic [7:0]  CMD_READ       = 8'h05
) (
    input logic           clk,
    input logic           reset,
    dbgu32_host_if.master bus
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SEND_SETADR = 3'd1,
        SEND_ADR    = 3'd2,
        SEND_OP     = 3'd3,
        SEND_DATA   = 3'd4,
        RECV        = 3'd5,
        DONE        = 3'd6
    } state_t;

    state_t           state_r;
    logic             we_r;
    logic [31:0]      adr_r;
    logic [31:0]      wdata_r;
    logic [1:0]       idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic [23:0]      rx_word_r;
    logic             tx_fire_s;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    assign tx_fire_s = bus.tx_valid & bus.tx_ready;

    // Protocol sequencer; every output is a register so the UART side sees clean levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            we_r          <= 1'b0;
            adr_r         <= 32'd0;
            wdata_r       <= 32'd0;
            idx_r         <= 2'd0;
            cnt_r         <= '0;
            rx_word_r     <= 24'd0;
            bus.req_ready <= 1'b1;
            bus.tx_valid  <= 1'b0;
            bus.tx_byte   <= 8'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        we_r          <= bus.req_we;
                        adr_r         <= bus.req_adr;
                        wdata_r       <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        bus.tx_valid  <= 1'b1;
                        bus.tx_byte   <= CMD_SET_ADR;
                        state_r       <= SEND_SETADR;
                    end
                end
                SEND_SETADR: begin
                    if (tx_fire_s) begin
                        bus.tx_byte <= byte_sel(adr_r, 2'd0);
                        idx_r       <= 2'd0;
                        state_r     <= SEND_ADR;
                    end
                end
                SEND_ADR: begin
                    if (tx_fire_s) begin
                        if (idx_r == 2'd3) begin
                            bus.tx_byte <= we_r ? CMD_WRITE : CMD_READ;
                            state_r     <= SEND_OP;
                        end else begin
                            bus.tx_byte <= byte_sel(adr_r, idx_r + 2'd1);
                            idx_r       <= idx_r + 2'd1;
                        end
                    end
                end
                SEND_OP: begin
                    if (tx_fire_s) begin
                        idx_r <= 2'd0;
                        if (we_r) begin
                            bus.tx_byte <= byte_sel(wdata_r, 2'd0);
                            state_r     <= SEND_DATA;
                        end else begin
                            bus.tx_valid <= 1'b0;
                            cnt_r        <= '0;
                            state_r      <= RECV;
                        end
                    end
                end
                SEND_DATA: begin
                    if (tx_fire_s) begin
                        if (idx_r == 2'd3) begin
                            bus.tx_valid  <= 1'b0;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_rdata <= 32'd0;
                            state_r       <= DONE;
                        end else begin
                            bus.tx_byte <= byte_sel(wdata_r, idx_r + 2'd1);
                            idx_r       <= idx_r + 2'd1;
                        end
                    end
                end
                RECV: begin
                    // A byte arriving on the terminal count still counts; timeout only without one.
                    if (bus.rx_valid) begin
                        cnt_r <= '0;
                        if (idx_r == 2'd3) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_rdata <= {bus.rx_byte, rx_word_r};
                            state_r       <= DONE;
                        end else begin
                            rx_word_r[{idx_r, 3'b000} +: 8] <= bus.rx_byte;
                            idx_r                           <= idx_r + 2'd1;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= 32'd0;
                        state_r       <= DONE;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state_r       <= IDLE;
                end
                default: begin
                    bus.tx_valid  <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state_r       <= IDLE;
                end
            endcase
        end
    end
endmodule
